// File: rtl/pam_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pam_pkg
//  Description : Shared types and constants for the PAM modulator and the
//                matching demodulator. The demodulator slicer thresholds sit
//                halfway between the rectified mean levels.
//  Revision    : 1.0 - initial release
// ============================================================================
package pam_pkg;

    localparam int SYM_W         = 2;
    localparam int SAMPLE_W      = 8;
    localparam int SYMS_PER_BYTE = 4;

    // Default amplitude per symbol unit.
    localparam int AMP_STEP_DEF  = 19;

    // Demodulator slicer thresholds (9/28/47 at the default step).
    localparam int SLICE_THR_1   = AMP_STEP_DEF / 2;
    localparam int SLICE_THR_2   = AMP_STEP_DEF + AMP_STEP_DEF / 2;
    localparam int SLICE_THR_3   = 2 * AMP_STEP_DEF + AMP_STEP_DEF / 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } pam_state_t;

    // Unsigned carrier amplitude for a symbol. With 3*step <= 127 the result
    // always fits the positive half of a signed sample.
    function automatic logic [SAMPLE_W-1:0] sym_level(
        input logic [SYM_W-1:0] sym,
        input int               step
    );
        sym_level = SAMPLE_W'(int'(sym) * step);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pam_carrier_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pam_carrier_gen
//  Description : Square-wave carrier sign generator. The sign is held for
//                CARRIER_HALF samples and then flips. The phase restarts on
//                every symbol boundary so each symbol has the same shape.
//  Ports       : clk, rst_n      - clock, async active-low reset
//                run             - the next cycle carries a sample
//                restart         - the next sample is the first of a symbol
//                sign_next       - sign of the next sample (1 = negative)
//  Revision    : 1.0 - initial release
// ============================================================================
module pam_carrier_gen
    import pam_pkg::*;
#(
    parameter int CARRIER_HALF = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic restart,
    output logic sign_next
);

    localparam int PW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

    logic [PW-1:0] phase_cnt;
    logic [PW-1:0] phase_next;
    logic          sign;
    logic          wrap;

    // Next-sample values are produced combinationally so the top level can
    // register the sample in the same edge as its counters.
    always_comb begin
        wrap       = (phase_cnt == PW'(CARRIER_HALF - 1));
        phase_next = '0;
        sign_next  = 1'b0;
        if (run && !restart) begin
            if (wrap) begin
                phase_next = '0;
                sign_next  = ~sign;
            end else begin
                phase_next = phase_cnt + PW'(1);
                sign_next  = sign;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_cnt <= '0;
            sign      <= 1'b0;
        end else begin
            phase_cnt <= phase_next;
            sign      <= sign_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pam_modulator.sv
`default_nettype none
// ============================================================================
//  Module      : pam_modulator
//  Description : Byte-to-PAM transmitter. Each accepted byte is sent as four
//                2-bit symbols, MSB pair first; each symbol is
//                SAMPLES_PER_SYM samples of a square-wave carrier with
//                amplitude sym*AMP_STEP.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                in_data/in_valid/in_ready - byte input handshake
//                out_sample            - signed transmit sample
//                sym_out               - symbol currently on air
//                sym_start             - first sample of a symbol
//                busy                  - byte in transmission
//  Revision    : 1.0 - initial release
// ============================================================================
module pam_modulator
    import pam_pkg::*;
#(
    parameter int SAMPLES_PER_SYM = 16,
    parameter int CARRIER_HALF    = 2,
    parameter int AMP_STEP        = AMP_STEP_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [SAMPLE_W-1:0] out_sample,
    output logic [SYM_W-1:0]    sym_out,
    output logic                sym_start,
    output logic                busy
);

    localparam int CW = $clog2(SAMPLES_PER_SYM);

    pam_state_t          state;
    pam_state_t          state_next;
    logic [1:0]          sym_idx;
    logic [1:0]          sym_idx_next;
    logic [CW-1:0]       sample_cnt;
    logic [CW-1:0]       sample_cnt_next;
    logic [7:0]          shreg;
    logic [7:0]          shreg_next;
    logic [SYM_W-1:0]    sym_next;
    logic [SAMPLE_W-1:0] level;
    logic                last_sample;
    logic                sym_wrap;
    logic                accept;
    logic                restart;
    logic                run;
    logic                sign_next;

    // Everything is computed for the *next* sample so the registered outputs
    // line up with the registered counters; the first sample therefore shows
    // right after the accepting edge.
    always_comb begin
        sym_wrap        = (sample_cnt == CW'(SAMPLES_PER_SYM - 1));
        last_sample     = (state == SEND) && sym_wrap &&
                          (sym_idx == 2'(SYMS_PER_BYTE - 1));
        in_ready        = (state == IDLE) || last_sample;
        accept          = in_valid && in_ready;

        state_next      = IDLE;
        sym_idx_next    = '0;
        sample_cnt_next = '0;
        shreg_next      = shreg;
        restart         = 1'b0;

        if (accept) begin
            state_next = SEND;
            shreg_next = in_data;
            restart    = 1'b1;
        end else if (state == SEND && !last_sample) begin
            state_next = SEND;
            if (sym_wrap) begin
                sym_idx_next = sym_idx + 2'd1;
                shreg_next   = {shreg[5:0], 2'b00};
                restart      = 1'b1;
            end else begin
                sym_idx_next    = sym_idx;
                sample_cnt_next = sample_cnt + CW'(1);
            end
        end

        run      = (state_next == SEND);
        // The current symbol is always the top pair of the shift register.
        sym_next = run ? shreg_next[7:6] : '0;
        level    = sym_level(sym_next, AMP_STEP);
    end

    pam_carrier_gen #(
        .CARRIER_HALF (CARRIER_HALF)
    ) u_carrier (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .restart   (restart),
        .sign_next (sign_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sym_idx    <= '0;
            sample_cnt <= '0;
            shreg      <= '0;
            out_sample <= '0;
            sym_out    <= '0;
            sym_start  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            sym_idx    <= sym_idx_next;
            sample_cnt <= sample_cnt_next;
            shreg      <= shreg_next;
            sym_out    <= sym_next;
            sym_start  <= run && restart;
            busy       <= run;
            if (!run)
                out_sample <= '0;
            else if (sign_next)
                out_sample <= -level;
            else
                out_sample <= level;
        end
    end

endmodule
`default_nettype wire

// File: doc/pam_modulator.md
Name: pam_modulator

Overview:
Transmit-side stage directly upstream of the PAM demodulator. Accepts bytes over a valid/ready handshake and splits each byte into four 2-bit symbols, MSB pair first. Each symbol is emitted as SAMPLES_PER_SYM signed 8-bit samples: a square-wave carrier whose amplitude is symbol × AMP_STEP. Rectified and averaged, the output gives mean levels 0/19/38/57 at defaults. These sit mid-band of the demodulator slicer thresholds (9/28/47).

Parameters:
SAMPLES_PER_SYM, 16, samples per symbol; must be a multiple of 2*CARRIER_HALF and ≥ 2*CARRIER_HALF
CARRIER_HALF, 2, samples per carrier half-period (sign held constant)
AMP_STEP, 19, amplitude per symbol unit; 3*AMP_STEP ≤ 127

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  8  byte to transmit
in_valid  input  1  in_data valid
in_ready  output  1  block can accept a byte this cycle
out_sample  output  8  signed transmit sample (two's complement)
sym_out  output  2  symbol currently being transmitted (verification/debug)
sym_start  output  1  one-cycle pulse coincident with the first sample of each symbol
busy  output  1  high while a byte is being transmitted

Behaviour:
- Clock/reset: single clock; reset asynchronous, active-low, per the decided interface.
- Reset values: state IDLE; out_sample 0; sym_out 0; sym_start 0; busy 0; all counters 0. in_ready is 1 once rst_n deasserts.
- FSM has two states: IDLE and SEND.
- in_ready is combinational. It is 1 in IDLE, and 1 in SEND only on the final sample cycle of symbol 3, i.e. sym_idx==3 and sample_cnt==SAMPLES_PER_SYM-1.
- Accept: on a rising edge with in_valid && in_ready, the byte is loaded into the shift register.
  - Next cycle: state SEND, sym_idx 0, sample_cnt 0, phase_cnt 0.
  - Latency is 1 cycle from the accepting edge to the first sample on out_sample.
- Symbol order: in_data[7:6], [5:4], [3:2], [1:0].
- Sample generation: out_sample = sign × sym × AMP_STEP.
  - sign is + for the first CARRIER_HALF samples, − for the next CARRIER_HALF, and so on.
  - The carrier phase restarts at every symbol boundary, so every symbol has an identical waveform shape.
  - Symbol 0 gives all-zero samples.
  - Products are precomputed 8-bit constants; no overflow is possible given the AMP_STEP constraint.
- Symbol and sample indexing:
  - sym_start is 1 when sample_cnt==0 in SEND.
  - sym_out holds the current symbol for all samples of that symbol.
  - sample_cnt wraps at SAMPLES_PER_SYM−1 and increments sym_idx.
- End of byte: after the last sample of symbol 3:
  - If a new byte was accepted on that cycle, the next cycle starts its symbol 0 with no gap (back-to-back).
  - Otherwise: state IDLE, out_sample 0, busy 0, sym_out 0 on the next cycle.
- Holding input: in_valid asserted while in_ready is 0 is ignored. in_data may change freely; the upstream must hold it until the handshake completes.
- Reset mid-byte: immediately returns to the reset values. The remaining symbols are dropped and not resumed.
- busy is 1 exactly while in SEND.
- All outputs except in_ready are registered.

Decomposition:
- pam_pkg holds:
  - SYM_W=2, SAMPLE_W=8, SYMS_PER_BYTE=4;
  - the state enum {IDLE, SEND};
  - a function mapping a symbol to its unsigned level (sym*AMP_STEP).
- The demodulator imports the same package, so threshold constants derived from AMP_STEP live there as well.
- One natural sub-module, pam_carrier_gen. It holds the phase counter, restarts on a sym_start-equivalent input, and outputs a sign bit.
- The top module owns the FSM, counters, shift register and sample multiplexing.

Test Plan:
- Reset release with in_valid=0 → in_ready=1, out_sample=0, busy=0 indefinitely.
- Single byte 0xE4 (symbols 3,2,1,0) → samples start 1 cycle after the handshake.
  - Symbol 3: +57,+57,−57,−57 repeated for 16 samples. Symbol 2 uses ±38 and symbol 1 uses ±19 with the same pattern; symbol 0 is 16 zeros.
  - sym_start pulses at cycles 0/16/32/48; busy is high for 64 cycles, then out_sample=0.
- Back-to-back 0xFF then 0x00 with in_valid held → second handshake occurs on sample 63.
  - Output is 64 samples of ±57 followed immediately by 64 zeros, with no idle cycle.
- in_valid with in_data toggled mid-transmission → in_ready stays 0, the transmitted symbols are unaffected, and the new byte is accepted only at the final sample.
- rst_n pulsed low at sample 20 of byte 0xAA → out_sample goes 0 asynchronously. On release the block is IDLE and in_ready=1; the next byte 0x55 transmits from symbol 0.
- Loopback with the demodulator on random bytes → after filter settling, the demodulator output matches sym_out delayed by the demodulator latency, for every symbol.
